// File: rtl/input_layer_rd_scheduler_if.sv
// AR channel of the input-layer fetch master plus the R-channel handshake
// bits the scheduler watches to retire outstanding bursts.
interface input_layer_rd_scheduler_if #(
  parameter int C_S_AXI_ID_WIDTH   = 3,
  parameter int C_S_AXI_ADDR_WIDTH = 32
);
  logic [C_S_AXI_ID_WIDTH-1:0]   arid;
  logic [C_S_AXI_ADDR_WIDTH-1:0] araddr;
  logic [7:0]                    arlen;
  logic [2:0]                    arsize;
  logic [1:0]                    arburst;
  logic                          arvalid;
  logic                          arready;
  logic                          rvalid;
  logic                          rready;
  logic                          rlast;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready, rvalid, rready, rlast
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready, rvalid, rready, rlast
  );
endinterface

// File: rtl/input_layer_rd_scheduler.sv
// Walks bursts x rows x layers of the input feature maps, issuing row-strided
// INCR reads on AR with a bounded outstanding count; R is only observed.
module input_layer_rd_scheduler #(
  parameter int C_S_AXI_ID_WIDTH   = 3,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int MAX_OUTSTANDING    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] axi_address,
  input  logic [15:0] allocated_space_per_row,
  input  logic [3:0]  burst_per_row,
  input  logic [7:0]  read_burst_len,
  input  logic [7:0]  no_of_input_layers,
  input  logic [9:0]  input_layer_row_size,
  input  logic        in_layer_ddr3_data_rdy,
  output logic        busy,
  output logic        done,
  output logic        row_fetched,
  input_layer_rd_scheduler_if.master m_axi
);
  localparam int AW         = C_S_AXI_ADDR_WIDTH;
  localparam int BEAT_BYTES = C_S_AXI_DATA_WIDTH / 8;
  localparam int SIZE       = $clog2(BEAT_BYTES);
  localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_RDY, S_ISSUE, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [AW-1:0] pitch;
    logic [AW-1:0] stride;
    logic [3:0]    bpr;
    logic [9:0]    rows;
    logic [7:0]    layers;
  } cfg_t;

  state_t           state;
  cfg_t             cfg;
  logic [3:0]       burst_cnt;
  logic [9:0]       row_cnt;
  logic [7:0]       layer_cnt;
  logic [3:0]       comp_cnt;
  logic [OUT_W-1:0] outstanding;
  logic [AW-1:0]    row_base;
  logic [AW-1:0]    burst_off;

  logic             ar_hs, rl_hs;
  logic             burst_wrap, row_wrap, layer_wrap, last_burst, comp_wrap;
  logic [OUT_W-1:0] outstanding_nxt;
  logic             credit_nxt;
  logic [AW-1:0]    row_base_nxt, burst_off_nxt;

  assign m_axi.arid    = '0;
  assign m_axi.arsize  = 3'(SIZE);
  assign m_axi.arburst = 2'b01;

  assign ar_hs = m_axi.arvalid & m_axi.arready;
  // An RLAST with nothing outstanding is stray and must not underflow.
  assign rl_hs = m_axi.rvalid & m_axi.rready & m_axi.rlast & (outstanding != '0);

  assign burst_wrap = (burst_cnt == cfg.bpr - 4'd1);
  assign row_wrap   = (row_cnt   == cfg.rows - 10'd1);
  assign layer_wrap = (layer_cnt == cfg.layers - 8'd1);
  assign last_burst = burst_wrap & row_wrap & layer_wrap;
  assign comp_wrap  = (comp_cnt  == cfg.bpr - 4'd1);

  always_comb begin
    outstanding_nxt = outstanding;
    if (ar_hs && !rl_hs)      outstanding_nxt = outstanding + OUT_W'(1);
    else if (!ar_hs && rl_hs) outstanding_nxt = outstanding - OUT_W'(1);
  end

  assign credit_nxt = (outstanding_nxt < OUT_W'(MAX_OUTSTANDING));

  // Rows are contiguous across layers, so a row wrap is the only place the
  // base moves; within a row only the burst offset advances.
  assign row_base_nxt  = burst_wrap ? row_base + cfg.pitch : row_base;
  assign burst_off_nxt = burst_wrap ? '0 : burst_off + cfg.stride;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      cfg           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      row_fetched   <= 1'b0;
      m_axi.arvalid <= 1'b0;
      m_axi.araddr  <= '0;
      m_axi.arlen   <= '0;
      burst_cnt     <= '0;
      row_cnt       <= '0;
      layer_cnt     <= '0;
      comp_cnt      <= '0;
      outstanding   <= '0;
      row_base      <= '0;
      burst_off     <= '0;
    end else begin
      done        <= 1'b0;
      row_fetched <= 1'b0;
      outstanding <= outstanding_nxt;

      if (rl_hs) begin
        if (comp_wrap) begin
          comp_cnt    <= '0;
          row_fetched <= 1'b1;
        end else begin
          comp_cnt <= comp_cnt + 4'd1;
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            cfg.pitch   <= AW'(allocated_space_per_row);
            cfg.stride  <= AW'({1'b0, read_burst_len} + 9'd1) << SIZE;
            cfg.bpr     <= burst_per_row;
            cfg.rows    <= input_layer_row_size;
            cfg.layers  <= no_of_input_layers;
            m_axi.arlen <= read_burst_len;
            row_base    <= AW'(axi_address);
            burst_off   <= '0;
            burst_cnt   <= '0;
            row_cnt     <= '0;
            layer_cnt   <= '0;
            comp_cnt    <= '0;
            outstanding <= '0;
            busy        <= 1'b1;
            if (burst_per_row == '0 || input_layer_row_size == '0 ||
                no_of_input_layers == '0)
              state <= S_DONE;
            else
              state <= S_WAIT_RDY;
          end
        end

        S_WAIT_RDY: begin
          if (in_layer_ddr3_data_rdy) begin
            state         <= S_ISSUE;
            m_axi.arvalid <= 1'b1;
            m_axi.araddr  <= row_base + burst_off;
          end
        end

        S_ISSUE: begin
          if (ar_hs) begin
            burst_cnt <= burst_wrap ? 4'd0 : burst_cnt + 4'd1;
            if (burst_wrap) row_cnt <= row_wrap ? 10'd0 : row_cnt + 10'd1;
            if (burst_wrap && row_wrap) layer_cnt <= layer_wrap ? 8'd0 : layer_cnt + 8'd1;
            row_base     <= row_base_nxt;
            burst_off    <= burst_off_nxt;
            m_axi.araddr <= row_base_nxt + burst_off_nxt;
            if (last_burst) begin
              m_axi.arvalid <= 1'b0;
              state         <= S_DRAIN;
            end else begin
              m_axi.arvalid <= credit_nxt;
            end
          end else if (!m_axi.arvalid) begin
            // A raised arvalid holds until accepted; only re-arm when idle.
            m_axi.arvalid <= credit_nxt;
          end
        end

        S_DRAIN: begin
          if (outstanding_nxt == '0) state <= S_DONE;
        end

        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_input_layer_rd_scheduler.sv
// Directed bench for the input-layer read scheduler: a burst-accurate memory
// responder, an AR monitor with an index-based address model, and scenarios.
module tb_input_layer_rd_scheduler;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] axi_address;
  logic [15:0] allocated_space_per_row;
  logic [3:0]  burst_per_row;
  logic [7:0]  read_burst_len;
  logic [7:0]  no_of_input_layers;
  logic [9:0]  input_layer_row_size;
  logic        in_layer_ddr3_data_rdy;
  logic        busy, done, row_fetched;

  input_layer_rd_scheduler_if #(.C_S_AXI_ID_WIDTH(3), .C_S_AXI_ADDR_WIDTH(32)) axi ();

  input_layer_rd_scheduler #(
    .C_S_AXI_ID_WIDTH(3), .C_S_AXI_ADDR_WIDTH(32),
    .C_S_AXI_DATA_WIDTH(64), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .axi_address(axi_address),
    .allocated_space_per_row(allocated_space_per_row),
    .burst_per_row(burst_per_row), .read_burst_len(read_burst_len),
    .no_of_input_layers(no_of_input_layers),
    .input_layer_row_size(input_layer_row_size),
    .in_layer_ddr3_data_rdy(in_layer_ddr3_data_rdy),
    .busy(busy), .done(done), .row_fetched(row_fetched),
    .m_axi(axi)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, cyc = 0;
  int ar_count, rl_count, rf_count, done_count, max_out;
  int last_rl_cyc, last_rf_cyc, done_cyc, start_cyc;
  logic busy_at_done;
  logic [31:0] addr_q[$];
  int pend[$];
  int beats_left = 0, grant = 0;
  bit mem_en = 1'b1, ar_rand = 1'b0;
  logic hold_pend = 1'b0;
  logic [31:0] hold_addr;
  int e_base, e_pitch, e_bpr, e_len;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int idx);
    if (e_bpr == 0) return 32'hFFFF_FFFF;
    return 32'(e_base + (idx / e_bpr) * e_pitch + (idx % e_bpr) * ((e_len + 1) * 8));
  endfunction

  // Monitor: sampled on the falling edge, so it sees what the next rising edge will take.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!reset_n) hold_pend = 1'b0;
    else begin
      if (hold_pend) begin
        chk("ar_hold_vld", axi.arvalid, 1);
        chk("ar_hold_addr", axi.araddr, hold_addr);
      end
      hold_pend = axi.arvalid && !axi.arready;
      hold_addr = axi.araddr;
      if (axi.arvalid && axi.arready) begin
        chk("araddr", axi.araddr, exp_addr(ar_count));
        chk("arlen", axi.arlen, e_len);
        chk("arsize", axi.arsize, 3);
        pend.push_back(int'(axi.arlen) + 1);
        addr_q.push_back(axi.araddr);
        ar_count++;
      end
      if (axi.rvalid && axi.rready && axi.rlast) begin rl_count++; last_rl_cyc = cyc; end
      if (row_fetched) begin rf_count++; last_rf_cyc = cyc; end
      if (done) begin done_count++; done_cyc = cyc; busy_at_done = busy; end
      if (ar_count - rl_count > max_out) max_out = ar_count - rl_count;
    end
  end

  // Memory responder: arlen+1 beats per accepted burst, in order.
  initial forever begin
    @(posedge clk); #1;
    if (!reset_n) begin
      pend.delete(); beats_left = 0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
    end else if ((mem_en || grant > 0) && (beats_left > 0 || pend.size() > 0)) begin
      if (beats_left == 0) beats_left = pend.pop_front();
      if (!mem_en) grant--;
      axi.rvalid = 1'b1;
      axi.rlast  = (beats_left == 1);
      beats_left--;
    end else begin
      axi.rvalid = 1'b0; axi.rlast = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    axi.arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic do_start(input int base, input int pitch, input int bpr,
                          input int len, input int rows, input int layers);
    e_base = base; e_pitch = pitch; e_bpr = bpr; e_len = len;
    ar_count = 0; rl_count = 0; rf_count = 0; done_count = 0; max_out = 0;
    last_rl_cyc = 0; last_rf_cyc = 0; done_cyc = 0; busy_at_done = 1'bx;
    addr_q.delete();
    axi_address = 32'(base); allocated_space_per_row = 16'(pitch);
    burst_per_row = 4'(bpr); read_burst_len = 8'(len);
    input_layer_row_size = 10'(rows); no_of_input_layers = 8'(layers);
    @(posedge clk); #1;
    start = 1'b1; start_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the configuration; the latched copy must be used.
    axi_address = 32'hDEAD_0000; allocated_space_per_row = 16'h0040;
    burst_per_row = 4'd7; read_burst_len = 8'd3;
    input_layer_row_size = 10'd5; no_of_input_layers = 8'd9;
  endtask

  task automatic wait_done(input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic check_first_ar();
    @(negedge clk);
    chk("busy_n1", busy, 1);
    chk("arvalid_n1", axi.arvalid, 0);
    @(negedge clk);
    chk("arvalid_n2", axi.arvalid, 1);
    chk("araddr_n2", axi.araddr, 32'h1000);
  endtask

  task automatic check_nominal(input string tag);
    chk({tag, "_ar_cnt"}, ar_count, 226);
    chk({tag, "_last_addr"}, addr_q[addr_q.size()-1], 32'h0000_F080);
    chk({tag, "_rows"}, rf_count, 113);
    chk({tag, "_done_cnt"}, done_count, 1);
    chk({tag, "_rf_lat"}, last_rf_cyc - last_rl_cyc, 1);
    chk({tag, "_done_lat"}, done_cyc - last_rl_cyc, 2);
    chk({tag, "_busy_at_done"}, busy_at_done, 0);
  endtask

  initial begin
    int av_seen;
    bit hit;
    reset_n = 1'b0; start = 1'b0; in_layer_ddr3_data_rdy = 1'b1;
    axi_address = '0; allocated_space_per_row = '0; burst_per_row = '0;
    read_burst_len = '0; no_of_input_layers = '0; input_layer_row_size = '0;
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rready = 1'b1; axi.arready = 1'b1;
    e_base = 0; e_pitch = 0; e_bpr = 1; e_len = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);        chk("rst_done", done, 0);
    chk("rst_row_fetched", row_fetched, 0);
    chk("rst_arvalid", axi.arvalid, 0); chk("rst_araddr", axi.araddr, 0);
    chk("rst_arid", axi.arid, 0);    chk("rst_arlen", axi.arlen, 0);
    chk("rst_arsize", axi.arsize, 3); chk("rst_arburst", axi.arburst, 1);
    @(posedge clk); #1; reset_n = 1'b1;

    // Nominal single-layer walk
    do_start(32'h1000, 512, 2, 15, 113, 1);
    check_first_ar();
    wait_done(20000);
    check_nominal("nom");
    chk("nom_busy_after", busy, 0);

    // Two layers of three rows
    do_start(32'h1000, 512, 2, 15, 3, 2);
    wait_done(2000);
    chk("ml_ar_cnt", ar_count, 12);
    chk("ml_layer1_first", addr_q[6], 32'h1600);
    chk("ml_last_addr", addr_q[addr_q.size()-1], 32'h1A80);
    chk("ml_rows", rf_count, 6);

    // Backpressure on AR
    ar_rand = 1'b1;
    do_start(32'h1000, 512, 2, 15, 113, 1);
    wait_done(20000);
    check_nominal("bp");
    ar_rand = 1'b0;

    // Outstanding limit, single-beat bursts, R released one RLAST at a time
    mem_en = 1'b0; grant = 0;
    do_start(32'h1000, 512, 2, 0, 113, 1);
    repeat (20) @(negedge clk);
    chk("lim_ar4", ar_count, 4);
    chk("lim_arvalid_lo", axi.arvalid, 0);
    @(posedge clk); #1; grant = 1;
    repeat (10) @(negedge clk);
    chk("lim_ar5", ar_count, 5);
    chk("lim_arvalid_lo2", axi.arvalid, 0);
    @(posedge clk); #1; grant = 2;
    repeat (10) @(negedge clk);
    chk("lim_ar7", ar_count, 7);
    chk("lim_arvalid_lo3", axi.arvalid, 0);
    chk("lim_max_out", max_out, 4);
    @(posedge clk); #1; reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; reset_n = 1'b1; mem_en = 1'b1; grant = 0;

    // Readiness gate
    in_layer_ddr3_data_rdy = 1'b0;
    do_start(32'h1000, 512, 1, 15, 1, 1);
    av_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi.arvalid) av_seen++;
    end
    chk("rdy_gate", av_seen, 0);
    @(posedge clk); #1; in_layer_ddr3_data_rdy = 1'b1;
    @(negedge clk);
    chk("rdy_av_r0", axi.arvalid, 0);
    @(negedge clk);
    chk("rdy_av_r1", axi.arvalid, 1);
    wait_done(500);
    chk("rdy_ar_cnt", ar_count, 1);
    chk("rdy_done_cnt", done_count, 1);

    // Degenerate configuration
    do_start(32'h1000, 512, 0, 15, 113, 1);
    @(negedge clk);
    chk("deg_busy_n1", busy, 1);
    wait_done(50);
    chk("deg_done_lat", done_cyc - start_cyc, 2);
    chk("deg_ar_cnt", ar_count, 0);
    chk("deg_done_cnt", done_count, 1);

    // Reset after the 50th AR
    do_start(32'h1000, 512, 2, 15, 113, 1);
    hit = 1'b0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      @(negedge clk);
      if (ar_count >= 50) hit = 1'b1;
    end
    chk("rst_reached_50", hit, 1);
    @(posedge clk); #1; reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy", busy, 0);          chk("mid_done", done, 0);
    chk("mid_row_fetched", row_fetched, 0);
    chk("mid_arvalid", axi.arvalid, 0); chk("mid_araddr", axi.araddr, 0);
    chk("mid_arlen", axi.arlen, 0);    chk("mid_arburst", axi.arburst, 1);
    @(posedge clk); #1; reset_n = 1'b1;

    // Restart, plus a start pulse while busy that must be ignored
    do_start(32'h1000, 512, 2, 15, 113, 1);
    check_first_ar();
    repeat (5) @(posedge clk);
    #1; axi_address = 32'h8000; burst_per_row = 4'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(20000);
    check_nominal("rs");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/input_layer_rd_scheduler.md
# input_layer_rd_scheduler

AXI read-address scheduler for the input-layer fetch path. On `start` it walks every burst of every row of every input feature map, issuing INCR bursts on the AXI AR channel at row-strided addresses. It bounds the number of outstanding bursts, counts RLAST beats to report row completion, and signals `done` once all data has returned. It drives the AR channel of the master that feeds the 3x3 window generator; the R channel is monitored only.

## Interface
- `C_S_AXI_ID_WIDTH`, 3, AXI ID width.
- `C_S_AXI_ADDR_WIDTH`, 32, AXI address width.
- `C_S_AXI_DATA_WIDTH`, 64, AXI data width. Beat size is DATA_WIDTH/8 bytes.
- `MAX_OUTSTANDING`, 4, maximum number of accepted bursts that have not yet returned RLAST.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `start` in 1: single-cycle request. Configuration inputs are latched in the same cycle.
- `axi_address` in 32: base byte address of layer 0, row 0.
- `allocated_space_per_row` in 16: byte pitch between consecutive rows.
- `burst_per_row` in 4: number of bursts per row.
- `read_burst_len` in 8: AXI ARLEN value. Beats per burst = value+1.
- `no_of_input_layers` in 8: number of input maps. Maps are stored back to back.
- `input_layer_row_size` in 10: rows per map.
- `in_layer_ddr3_data_rdy` in 1: memory contents valid. Gates issue.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse.
- `row_fetched` out 1: one-cycle pulse when the final RLAST of a row is received.
- `M_axi_arid` out ID_WIDTH: constant 0.
- `M_axi_araddr` out ADDR_WIDTH: burst address.
- `M_axi_arlen` out 8: `read_burst_len`, as latched.
- `M_axi_arsize` out 3: log2(DATA_WIDTH/8), which is 3 for 64-bit.
- `M_axi_arburst` out 2: 2'b01 (INCR).
- `M_axi_arvalid` out 1: address valid.
- `M_axi_arready` in 1: address ready.
- `M_axi_rvalid` in 1: monitored.
- `M_axi_rready` in 1: monitored.
- `M_axi_rlast` in 1: monitored.

## Operation

**States:** IDLE, WAIT_RDY, ISSUE, DRAIN, DONE.

**IDLE**
- When `start` is seen, latch the configuration and clear all counters.
- If `burst_per_row`, `input_layer_row_size` or `no_of_input_layers` is 0, go to DONE. No AR is issued.
- Otherwise go to WAIT_RDY.

**WAIT_RDY**
- Stay until `in_layer_ddr3_data_rdy` is 1, then go to ISSUE.

**ISSUE**
- `arvalid` = 1 whenever `outstanding < MAX_OUTSTANDING`.
- On each AR handshake (`arvalid & arready`):
  - Advance the burst counter.
  - When the burst counter wraps (at `burst_per_row`), advance the row counter.
  - When the row counter wraps (at `input_layer_row_size`), advance the layer counter.
- After the handshake of the final burst, go to DRAIN.

**DRAIN**
- Stay until `outstanding == 0`, then go to DONE.

**DONE**
- Pulse `done` and return to IDLE.

**Address generation** (incremental, no multiplier, modulo 2^ADDR_WIDTH):
- `row_base` starts at `axi_address`.
- `burst_off` starts at 0.
- Each handshake adds `burst_stride` = (`read_burst_len`+1)*(DATA_WIDTH/8) to `burst_off`.
- On a row wrap, `row_base` += `allocated_space_per_row` and `burst_off` = 0. Rows continue contiguously across layers.
- `araddr` = `row_base` + `burst_off`.

**Outstanding counter**
- Width is clog2(MAX_OUTSTANDING+1).
- +1 on an AR handshake.
- −1 on `rvalid & rready & rlast`.
- Both in the same cycle: no change.
- Never exceeds MAX_OUTSTANDING and never underflows. An RLAST with outstanding = 0 is ignored.

**Row completion**
- A completed-burst counter counts RLASTs modulo `burst_per_row`.
- `row_fetched` pulses on each wrap.

**Other rules**
- `start` while `busy` is ignored.
- Changing the configuration inputs while busy has no effect.
- `in_layer_ddr3_data_rdy` is only checked in WAIT_RDY.

## Timing
- **Reset values:**
  - `busy`, `done`, `row_fetched`, `M_axi_arvalid` = 0.
  - `M_axi_araddr` = 0, `M_axi_arid` = 0.
  - `M_axi_arlen` = 0, `M_axi_arsize` = log2(DATA_WIDTH/8), `M_axi_arburst` = 2'b01.
  - State = IDLE, and all counters = 0.
- **Reset mid-operation:** returns to IDLE at the next edge with all outputs at reset values. The bench discards any outstanding responses.
- **AR hold rule:** once `arvalid` is 1, it and `araddr` hold stable until `arready`.
- **AR outputs are registered.** Back-to-back handshakes are allowed, giving one burst per cycle while `arready` is 1 and credit is available.
- **Start latency:** `start` at cycle N gives `busy` = 1 at N+1. With `in_layer_ddr3_data_rdy` = 1 at N+1, the first `arvalid` is at N+2.
- **Completion latency:** the final RLAST at cycle M gives `row_fetched` (if due) at M+1 and `done` at M+2. `busy` falls in the same cycle `done` is high.
- **Degenerate configuration:** `start` at N gives `done` at N+2.

## Test plan
1. **Nominal issue order.** Base 0x1000, pitch 512, `burst_per_row` 2, `read_burst_len` 15, 113 rows, 1 layer, `arready` always 1, and a memory model returning 16 beats per burst.
   - Exactly 226 ARs, at 0x1000, 0x1080, 0x1200, 0x1280, … with the last at 0xF080.
   - `arlen` = 15 and `arsize` = 3 on every AR.
   - 113 `row_fetched` pulses, then 1 `done`.
2. **Multiple layers.** Same settings, 3 rows, 2 layers.
   - The first AR of layer 1 is at 0x1600.
   - 12 ARs in total, and the last address is 0x1A80.
3. **Outstanding limit.** `rvalid` held 0.
   - Exactly 4 ARs are accepted, then `arvalid` stays 0.
   - Each RLAST then releases exactly one further AR.
   - An RLAST coincident with an AR handshake keeps outstanding at 4.
4. **Backpressure.** `arready` driven randomly at 50%.
   - `arvalid` and `araddr` never change while `arvalid & !arready`.
   - The address sequence is identical to scenario 1.
5. **Readiness gate and degenerate configuration.**
   - With `in_layer_ddr3_data_rdy` = 0 for 20 cycles, no `arvalid` is seen; the first `arvalid` comes 1 cycle after rdy rises.
   - With `burst_per_row` = 0: no AR, and `done` at N+2.
6. **Reset and restart.**
   - Assert `reset_n` = 0 after the 50th AR: all outputs return to reset values next cycle.
   - Restart with `start`: the first address is again 0x1000.
   - A `start` pulsed while busy changes nothing.
